// File: rtl/ps2_pkg.sv
// Shared constants and state types for the PS/2 key channelizer.
package ps2_pkg;

  localparam logic [7:0] PS2_E0    = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] CH_OFF    = 8'hF0;

  // Keyboard housekeeping bytes that never represent a key press
  localparam logic [7:0] IGN_BAT_OK = 8'hAA;
  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_ERR0   = 8'h00;
  localparam logic [7:0] IGN_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_E0,
    DEC_F0,
    DEC_E0F0
  } decode_state_t;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == IGN_BAT_OK) || (code == IGN_ACK)  || (code == IGN_RESEND) ||
           (code == IGN_ECHO)   || (code == IGN_ERR0) || (code == IGN_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_channelizer_if.sv
// Pin-side inputs and key/channel outputs of the PS/2 key channelizer.
interface ps2_key_channelizer_if;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] scan_code1;
  logic [7:0] scan_code2;
  logic [7:0] key1_code;
  logic       key_ext;
  logic       key_strobe;
  logic       frame_err;

  modport master (
    input  PS2_CLK, PS2_DAT,
    output scan_code1, scan_code2, key1_code, key_ext, key_strobe, frame_err
  );

  modport slave (
    output PS2_CLK, PS2_DAT,
    input  scan_code1, scan_code2, key1_code, key_ext, key_strobe, frame_err
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: pin synchronizers, clock glitch filter,
// 11-bit frame FSM and an inter-edge watchdog that aborts stalled frames.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       CLK_50,
  input  logic       RESET,
  input  logic       ps2_clk_pin,
  input  logic       ps2_dat_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   clk_filt, clk_filt_d, fall_evt;
  logic [FCW-1:0]         filt_cnt;
  logic [WDW-1:0]         wd_cnt;
  logic [7:0]             shift_reg;
  logic [2:0]             bit_cnt;
  logic                   par_bit;
  logic                   timeout;
  logic                   valid_next, err_next;
  frame_state_t           state, state_next;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign fall_evt = clk_filt_d & ~clk_filt;
  assign timeout  = (state != FR_IDLE) && !fall_evt && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
  assign rx_byte  = shift_reg;

  // Bring both idle-high pins into the CLK_50 domain
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_pin};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_pin};
    end
  end

  // Filtered clock only flips after FILTER_LEN consecutive samples of the new level
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame state register
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) state <= FR_IDLE;
    else        state <= state_next;
  end

  // Frame next-state: advance one field per falling edge, watchdog forces IDLE
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = FR_IDLE;
    end else if (fall_evt) begin
      case (state)
        FR_IDLE:   if (!dat_s) state_next = FR_DATA;
        FR_DATA:   if (bit_cnt == 3'd7) state_next = FR_PARITY;
        FR_PARITY: state_next = FR_STOP;
        FR_STOP:   state_next = FR_IDLE;
        default:   state_next = FR_IDLE;
      endcase
    end
  end

  // Frame outputs: good byte on a clean stop bit with odd parity, error otherwise
  always_comb begin
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (timeout) begin
      err_next = 1'b1;
    end else if (fall_evt) begin
      case (state)
        FR_IDLE: err_next = dat_s;
        FR_STOP: begin
          if (dat_s && (^{shift_reg, par_bit})) valid_next = 1'b1;
          else                                  err_next   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath: shifter, bit counter, parity capture, watchdog and registered pulses
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      wd_cnt    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= valid_next;
      frame_err <= err_next;
      if (fall_evt || state == FR_IDLE) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 1'b1;
      if (fall_evt) begin
        case (state)
          FR_IDLE:   bit_cnt <= '0;
          FR_DATA: begin
            shift_reg <= {dat_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          FR_PARITY: par_bit <= dat_s;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_channelizer.sv
// PS/2 keyboard front end for the staff/sound path: decodes make/break/E0
// sequences and assigns held note keys to two voice channels.
module ps2_key_channelizer
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input logic                   CLK_50,
  input logic                   RESET,
  ps2_key_channelizer_if.master bus
);

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_err;
  logic          is_make, is_break, seq_ext;
  logic [7:0]    scan1, scan2, key_code;
  logic          key_ext_r, key_strobe_r;
  decode_state_t dec_state, dec_next;

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .CLK_50      (CLK_50),
    .RESET       (RESET),
    .ps2_clk_pin (bus.PS2_CLK),
    .ps2_dat_pin (bus.PS2_DAT),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frame_err   (rx_err)
  );

  assign bus.scan_code1 = scan1;
  assign bus.scan_code2 = scan2;
  assign bus.key1_code  = key_code;
  assign bus.key_ext    = key_ext_r;
  assign bus.key_strobe = key_strobe_r;
  assign bus.frame_err  = rx_err;

  // Decode state register
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) dec_state <= DEC_NORMAL;
    else       dec_state <= dec_next;
  end

  // Decode next-state: prefixes accumulate, any other byte returns to NORMAL
  always_comb begin
    dec_next = dec_state;
    if (rx_valid) begin
      case (dec_state)
        DEC_NORMAL: begin
          if      (rx_byte == PS2_E0)    dec_next = DEC_E0;
          else if (rx_byte == PS2_BREAK) dec_next = DEC_F0;
        end
        DEC_E0:  dec_next = (rx_byte == PS2_BREAK) ? DEC_E0F0 : DEC_NORMAL;
        default: dec_next = DEC_NORMAL;
      endcase
    end
  end

  // Decode outputs: classify the received byte as make or break
  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    seq_ext  = 1'b0;
    if (rx_valid) begin
      case (dec_state)
        DEC_NORMAL: is_make = (rx_byte != PS2_E0) && (rx_byte != PS2_BREAK) && !is_ignored(rx_byte);
        DEC_E0: begin
          is_make = (rx_byte != PS2_BREAK);
          seq_ext = 1'b1;
        end
        DEC_F0: is_break = 1'b1;
        DEC_E0F0: begin
          is_break = 1'b1;
          seq_ext  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Key report and channel allocation; extended keys never occupy a channel
  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      scan1        <= CH_OFF;
      scan2        <= CH_OFF;
      key_code     <= 8'h00;
      key_ext_r    <= 1'b0;
      key_strobe_r <= 1'b0;
    end else begin
      key_strobe_r <= is_make;
      if (is_make) begin
        key_code  <= rx_byte;
        key_ext_r <= seq_ext;
        if (!seq_ext && rx_byte != scan1 && rx_byte != scan2) begin
          if      (scan1 == CH_OFF) scan1 <= rx_byte;
          else if (scan2 == CH_OFF) scan2 <= rx_byte;
        end
      end
      if (is_break && !seq_ext) begin
        if (rx_byte == scan1) scan1 <= CH_OFF;
        if (rx_byte == scan2) scan2 <= CH_OFF;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_channelizer.sv
// Scoreboard bench: a keyboard-level model predicts key reports, channel
// changes and frame errors; a monitor matches them against the DUT outputs.
module tb_ps2_key_channelizer;

  localparam int HALF        = 40;
  localparam int TIMEOUT_CYC = 5000;

  typedef enum int {EV_STROBE = 0, EV_CHAN = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] key;
    logic       ext;
    logic [7:0] c1;
    logic [7:0] c2;
  } ev_t;

  logic clk_50 = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  logic [7:0] m_ch[2];
  bit         m_pfx_e0, m_pfx_f0;

  always #10 clk_50 = ~clk_50;

  ps2_key_channelizer_if bus_if();

  ps2_key_channelizer dut (
    .CLK_50 (clk_50),
    .RESET  (reset),
    .bus    (bus_if)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [7:0] key, input logic ext);
    ev_t e;
    e.kind = k;
    e.key  = key;
    e.ext  = ext;
    e.c1   = m_ch[0];
    e.c2   = m_ch[1];
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_ch[0]  = 8'hF0;
    m_ch[1]  = 8'hF0;
    m_pfx_e0 = 0;
    m_pfx_f0 = 0;
  endfunction

  // Keyboard-level behaviour: prefixes set flags, the next byte completes a key event
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] old0, old1;
    old0 = m_ch[0];
    old1 = m_ch[1];
    if (b == 8'hE0 && !m_pfx_e0 && !m_pfx_f0) begin
      m_pfx_e0 = 1;
    end else if (b == 8'hF0 && !m_pfx_f0) begin
      m_pfx_f0 = 1;
    end else if (m_pfx_f0) begin
      if (!m_pfx_e0)
        for (int i = 0; i < 2; i++) if (m_ch[i] == b) m_ch[i] = 8'hF0;
      m_pfx_e0 = 0;
      m_pfx_f0 = 0;
      if (m_ch[0] != old0 || m_ch[1] != old1) push_ev(EV_CHAN, 8'h00, 1'b0);
    end else if (!m_pfx_e0 && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
    end else begin
      if (!m_pfx_e0 && b != m_ch[0] && b != m_ch[1]) begin
        if      (m_ch[0] == 8'hF0) m_ch[0] = b;
        else if (m_ch[1] == 8'hF0) m_ch[1] = b;
      end
      push_ev(EV_STROBE, b, m_pfx_e0);
      m_pfx_e0 = 0;
    end
  endfunction

  // Drive one keyboard frame (or its first nbits bits) onto the pins
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
    logic [10:0] frame;
    frame = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus_if.PS2_DAT = frame[i];
      if (i == glitch_bit) begin
        repeat (8) @(negedge clk_50);
        bus_if.PS2_CLK = 1'b0;
        repeat (2) @(negedge clk_50);
        bus_if.PS2_CLK = 1'b1;
        repeat (HALF/2 - 10) @(negedge clk_50);
      end else begin
        repeat (HALF/2) @(negedge clk_50);
      end
      bus_if.PS2_CLK = 1'b0;
      repeat (HALF) @(negedge clk_50);
      bus_if.PS2_CLK = 1'b1;
      repeat (HALF/2) @(negedge clk_50);
    end
    repeat (60) @(negedge clk_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    applyStimulus(b, 1'b0, 11, -1);
  endtask

  // Monitor: every observable output event must match the head of the queue
  initial begin
    logic [7:0] prev1, prev2;
    ev_t        e;
    int         ak;
    prev1 = 8'hF0;
    prev2 = 8'hF0;
    forever begin
      @(negedge clk_50);
      if (reset) begin
        prev1 = 8'hF0;
        prev2 = 8'hF0;
        continue;
      end
      if (bus_if.key_strobe || bus_if.frame_err ||
          bus_if.scan_code1 !== prev1 || bus_if.scan_code2 !== prev2) begin
        ak = bus_if.frame_err ? 2 : (bus_if.key_strobe ? 0 : 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got kind %0d expected none at %0t", ak, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind", ak, int'(e.kind));
          if (e.kind == EV_STROBE) begin
            checkOutput("key1_code", bus_if.key1_code, e.key);
            checkOutput("key_ext", bus_if.key_ext, e.ext);
          end
          if (e.kind != EV_ERR) begin
            checkOutput("scan_code1", bus_if.scan_code1, e.c1);
            checkOutput("scan_code2", bus_if.scan_code2, e.c2);
          end
        end
      end
      prev1 = bus_if.scan_code1;
      prev2 = bus_if.scan_code2;
    end
  end

  // Absolute time limit so a stuck run still ends with a report
  initial begin
    #5ms;
    $display("[TB] FAIL time_limit: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] time limit");
  end

  // Main stimulus: directed scenarios, reset mid-frame, then random key traffic
  initial begin
    logic [7:0] pool[7];
    logic [7:0] ign[6];
    logic [7:0] code;
    int         kind;
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h15, 8'h1D, 8'h24};
    ign  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    reset = 1'b1;
    bus_if.PS2_CLK = 1'b1;
    bus_if.PS2_DAT = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    checkOutput("rst_scan_code1", bus_if.scan_code1, 8'hF0);
    checkOutput("rst_scan_code2", bus_if.scan_code2, 8'hF0);
    checkOutput("rst_key1_code", bus_if.key1_code, 8'h00);
    checkOutput("rst_key_ext", bus_if.key_ext, 1'b0);
    checkOutput("rst_key_strobe", bus_if.key_strobe, 1'b0);
    checkOutput("rst_frame_err", bus_if.frame_err, 1'b0);

    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1B);
    send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23);
    for (int i = 0; i < 5; i++) send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    push_ev(EV_ERR, 8'h00, 1'b0);
    applyStimulus(8'h2B, 1'b1, 11, -1);

    push_ev(EV_ERR, 8'h00, 1'b0);
    applyStimulus(8'h2B, 1'b0, 4, -1);
    bus_if.PS2_DAT = 1'b1;
    repeat (TIMEOUT_CYC + 200) @(negedge clk_50);
    send_byte(8'h2B);

    send_byte(8'hF0);
    model_byte(8'h1C);
    applyStimulus(8'h1C, 1'b0, 11, 5);
    send_byte(8'h1C);

    applyStimulus(8'h2B, 1'b0, 5, -1);
    bus_if.PS2_DAT = 1'b1;
    repeat (HALF/2) @(negedge clk_50);
    bus_if.PS2_CLK = 1'b0;
    repeat (20) @(negedge clk_50);
    #3 reset = 1'b1;
    #1;
    checkOutput("midrst_scan_code1", bus_if.scan_code1, 8'hF0);
    checkOutput("midrst_scan_code2", bus_if.scan_code2, 8'hF0);
    model_reset();
    repeat (10) @(negedge clk_50);
    bus_if.PS2_CLK = 1'b1;
    bus_if.PS2_DAT = 1'b1;
    repeat (5) @(negedge clk_50);
    reset = 1'b0;
    repeat (5) @(negedge clk_50);
    send_byte(8'h1C);

    for (int n = 0; n < 20; n++) begin
      code = pool[$urandom_range(0, 6)];
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        send_byte(code);
      end else if (kind <= 6) begin
        send_byte(8'hF0); send_byte(code);
      end else if (kind == 7) begin
        send_byte(8'hE0); send_byte(code);
      end else if (kind == 8) begin
        send_byte(8'hE0); send_byte(8'hF0); send_byte(code);
      end else begin
        send_byte(ign[$urandom_range(0, 5)]);
      end
    end

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_50);
    checkOutput("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
